// File: rtl/ifid_branch_unit.sv
// IF/ID pipeline register with ID-stage branch resolution and hazard detection.
//
// The IF/ID register captures the fetched PC+4 and instruction. The held
// instruction is decoded in ID: beq/bne are resolved here by comparing the
// (forwarded) operand values, and j/jal/jr produce a jump target. Load-use and
// branch-operand hazards against the EX stage stall fetch and hold IF/ID. There
// is no delay slot, so a taken redirect replaces the wrong-path fetch with a
// bubble.
//
// Ports:
//   clk        clock, rising-edge state updates
//   clrn       asynchronous active-low reset
//   pc4, inst  PC+4 and instruction from the fetch stage
//   rs_data    value of d_rs (register file or forwarded)
//   rt_data    value of d_rt (register file or forwarded)
//   e_wreg     EX-stage instruction writes a register
//   e_m2reg    that write comes from a load
//   e_rn       EX-stage destination register
//   stall      fetch holds its PC this cycle
//   pcsource   next-PC select: 00 pc4, 01 bpc, 10 jpc
//   bpc, jpc   branch and jump targets
//   d_pc4      IF/ID PC+4
//   d_inst     IF/ID instruction
//   d_valid    d_inst is a real instruction (not a bubble)
//   d_rs, d_rt source register fields of d_inst
//   stall_cnt  saturating count of stalled edges
//   flush_cnt  saturating count of redirecting edges
module ifid_branch_unit (
    input  logic        clk,
    input  logic        clrn,
    input  logic [31:0] pc4,
    input  logic [31:0] inst,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        e_wreg,
    input  logic        e_m2reg,
    input  logic [4:0]  e_rn,
    output logic        stall,
    output logic [1:0]  pcsource,
    output logic [31:0] bpc,
    output logic [31:0] jpc,
    output logic [31:0] d_pc4,
    output logic [31:0] d_inst,
    output logic        d_valid,
    output logic [4:0]  d_rs,
    output logic [4:0]  d_rt,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpJal   = 6'b000011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] FnJr    = 6'b001000;

    localparam logic [1:0] PcSelPc4 = 2'b00;
    localparam logic [1:0] PcSelBpc = 2'b01;
    localparam logic [1:0] PcSelJpc = 2'b10;

    // IF/ID and counter state
    logic [31:0] pc4_q, pc4_d;
    logic [31:0] inst_q, inst_d;
    logic        valid_q, valid_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    // Decode
    logic [5:0] op;
    logic [5:0] funct;
    logic       is_beq, is_bne, is_j, is_jal, is_jr;
    logic       rn_nonzero, rn_hits_rs, rn_hits_rt;
    logic       load_use_hz, branch_hz;
    logic       redirect;

    assign op    = inst_q[31:26];
    assign funct = inst_q[5:0];
    assign d_rs  = inst_q[25:21];
    assign d_rt  = inst_q[20:16];

    // Bubbles are never decoded as control flow.
    assign is_beq = valid_q && (op == OpBeq);
    assign is_bne = valid_q && (op == OpBne);
    assign is_j   = valid_q && (op == OpJ);
    assign is_jal = valid_q && (op == OpJal);
    assign is_jr  = valid_q && (op == OpRtype) && (funct == FnJr);

    assign rn_nonzero = (e_rn != 5'd0);
    assign rn_hits_rs = (e_rn == d_rs);
    assign rn_hits_rt = (e_rn == d_rt);

    assign load_use_hz = valid_q && e_wreg && e_m2reg && rn_nonzero && (rn_hits_rs || rn_hits_rt);

    // Branches compare in ID, so any EX-stage producer of an operand must drain first.
    assign branch_hz = e_wreg && rn_nonzero &&
                       (((is_beq || is_bne) && (rn_hits_rs || rn_hits_rt)) ||
                        (is_jr && rn_hits_rs));

    assign stall = load_use_hz || branch_hz;

    assign bpc = pc4_q + {{14{inst_q[15]}}, inst_q[15:0], 2'b00};

    always_comb begin
        jpc = 32'd0;
        if (is_j || is_jal) begin
            jpc = {pc4_q[31:28], inst_q[25:0], 2'b00};
        end else if (is_jr) begin
            jpc = rs_data;
        end
    end

    always_comb begin
        pcsource = PcSelPc4;
        if (!stall) begin
            if ((is_beq && (rs_data == rt_data)) || (is_bne && (rs_data != rt_data))) begin
                pcsource = PcSelBpc;
            end else if (is_j || is_jal || is_jr) begin
                pcsource = PcSelJpc;
            end
        end
    end

    assign redirect = (pcsource != PcSelPc4);

    always_comb begin
        pc4_d       = pc4_q;
        inst_d      = inst_q;
        valid_d     = valid_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (stall) begin
            if (stall_cnt_q != 16'hFFFF) begin
                stall_cnt_d = stall_cnt_q + 16'd1;
            end
        end else if (redirect) begin
            // Squash the wrong-path fetch; no delay slot.
            pc4_d   = pc4;
            inst_d  = 32'd0;
            valid_d = 1'b0;
            if (flush_cnt_q != 16'hFFFF) begin
                flush_cnt_d = flush_cnt_q + 16'd1;
            end
        end else begin
            pc4_d   = pc4;
            inst_d  = inst;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            pc4_q       <= 32'd0;
            inst_q      <= 32'd0;
            valid_q     <= 1'b0;
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            pc4_q       <= pc4_d;
            inst_q      <= inst_d;
            valid_q     <= valid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign d_pc4     = pc4_q;
    assign d_inst    = inst_q;
    assign d_valid   = valid_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_ifid_branch_unit.sv
// Self-checking bench for ifid_branch_unit. Expected values are pushed to a
// scoreboard queue as stimulus is applied and popped/compared when the DUT
// outputs are sampled (1 time unit after the relevant clock edge or input change).
module tb_ifid_branch_unit;

    logic        clk;
    logic        clrn;
    logic [31:0] pc4, inst, rs_data, rt_data;
    logic        e_wreg, e_m2reg;
    logic [4:0]  e_rn;
    logic        stall;
    logic [1:0]  pcsource;
    logic [31:0] bpc, jpc, d_pc4, d_inst;
    logic        d_valid;
    logic [4:0]  d_rs, d_rt;
    logic [15:0] stall_cnt, flush_cnt;

    ifid_branch_unit dut (
        .clk       (clk),
        .clrn      (clrn),
        .pc4       (pc4),
        .inst      (inst),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .e_wreg    (e_wreg),
        .e_m2reg   (e_m2reg),
        .e_rn      (e_rn),
        .stall     (stall),
        .pcsource  (pcsource),
        .bpc       (bpc),
        .jpc       (jpc),
        .d_pc4     (d_pc4),
        .d_inst    (d_inst),
        .d_valid   (d_valid),
        .d_rs      (d_rs),
        .d_rt      (d_rt),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {
        SelStall, SelPcsrc, SelBpc, SelJpc, SelDpc4, SelDinst,
        SelDvalid, SelDrs, SelDrt, SelStallCnt, SelFlushCnt
    } sel_e;

    typedef struct {
        string       tag;
        sel_e        sel;
        logic [31:0] exp;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] InstAddi = 32'h20010005;
    localparam logic [31:0] InstBeq  = 32'h10220003;
    localparam logic [31:0] InstAdd  = 32'h00652020;  // add $4,$3,$5
    localparam logic [31:0] InstJr   = 32'h03E00008;  // jr $31
    localparam logic [31:0] InstJ    = 32'h08000100;  // j 0x100

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] observe(input sel_e sel);
        case (sel)
            SelStall:    return {31'd0, stall};
            SelPcsrc:    return {30'd0, pcsource};
            SelBpc:      return bpc;
            SelJpc:      return jpc;
            SelDpc4:     return d_pc4;
            SelDinst:    return d_inst;
            SelDvalid:   return {31'd0, d_valid};
            SelDrs:      return {27'd0, d_rs};
            SelDrt:      return {27'd0, d_rt};
            SelStallCnt: return {16'd0, stall_cnt};
            SelFlushCnt: return {16'd0, flush_cnt};
            default:     return 32'hxxxxxxxx;
        endcase
    endfunction

    task automatic push(input string tag, input sel_e sel, input logic [31:0] exp);
        sb_entry_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        sb_entry_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val(e.tag, observe(e.sel), e.exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] p, input logic [31:0] i);
        @(negedge clk);
        pc4  = p;
        inst = i;
    endtask

    function automatic logic [31:0] bpc_model(input logic [31:0] p, input logic [15:0] imm);
        logic [31:0] off;
        off = {{16{imm[15]}}, imm};
        return p + (off << 2);
    endfunction

    initial begin
        logic [31:0] rp, ri, ra, rb;
        logic [15:0] imm;
        logic        use_bne, taken;

        clrn = 1'b0;
        pc4 = 32'h1234; inst = InstBeq;
        rs_data = 32'd0; rt_data = 32'd0;
        e_wreg = 1'b0; e_m2reg = 1'b0; e_rn = 5'd0;

        // Reset holds everything at zero even with the clock running.
        repeat (2) @(posedge clk);
        #1;
        push("rst_dvalid", SelDvalid, 32'd0);
        push("rst_dinst", SelDinst, 32'd0);
        push("rst_dpc4", SelDpc4, 32'd0);
        push("rst_stall", SelStall, 32'd0);
        push("rst_pcsrc", SelPcsrc, 32'd0);
        push("rst_scnt", SelStallCnt, 32'd0);
        push("rst_fcnt", SelFlushCnt, 32'd0);
        drain();

        // Plain fetch after reset.
        @(negedge clk);
        clrn = 1'b1;
        pc4  = 32'h4;
        inst = InstAddi;
        tick();
        push("fetch_dinst", SelDinst, InstAddi);
        push("fetch_dvalid", SelDvalid, 32'd1);
        push("fetch_dpc4", SelDpc4, 32'h4);
        push("fetch_drs", SelDrs, 32'd0);
        push("fetch_drt", SelDrt, 32'd1);
        push("fetch_pcsrc", SelPcsrc, 32'd0);
        push("fetch_stall", SelStall, 32'd0);
        drain();

        // beq not taken: no bubble.
        drive(32'h10, InstBeq);
        tick();
        @(negedge clk);
        rs_data = 32'd7; rt_data = 32'd8;
        pc4 = 32'h10; inst = InstBeq;
        #1;
        push("beqnt_pcsrc", SelPcsrc, 32'd0);
        push("beqnt_bpc", SelBpc, 32'h1C);
        drain();
        tick();
        push("beqnt_dvalid", SelDvalid, 32'd1);
        push("beqnt_dinst", SelDinst, InstBeq);
        push("beqnt_fcnt", SelFlushCnt, 32'd0);
        drain();

        // beq taken: bubble, then target two edges after branch entered ID.
        @(negedge clk);
        rt_data = 32'd7;
        pc4 = 32'h14; inst = 32'hDEADBEEF;
        #1;
        push("beqt_pcsrc", SelPcsrc, 32'd1);
        push("beqt_bpc", SelBpc, 32'h1C);
        drain();
        tick();
        push("beqt_dvalid", SelDvalid, 32'd0);
        push("beqt_dinst", SelDinst, 32'd0);
        push("beqt_dpc4", SelDpc4, 32'h14);
        push("beqt_fcnt", SelFlushCnt, 32'd1);
        push("bubble_pcsrc", SelPcsrc, 32'd0);
        drain();
        drive(32'h20, 32'hAAAA0001);
        tick();
        push("target_dinst", SelDinst, 32'hAAAA0001);
        push("target_dvalid", SelDvalid, 32'd1);
        drain();

        // Load-use hazard on rs, then on rt, then cleared by e_rn = 0.
        drive(32'h24, InstAdd);
        tick();
        @(negedge clk);
        e_wreg = 1'b1; e_m2reg = 1'b1; e_rn = 5'd3;
        pc4 = 32'h28; inst = InstJr;
        #1;
        push("lu_stall", SelStall, 32'd1);
        push("lu_pcsrc", SelPcsrc, 32'd0);
        drain();
        tick();
        push("lu_dinst_held", SelDinst, InstAdd);
        push("lu_dpc4_held", SelDpc4, 32'h24);
        push("lu_scnt", SelStallCnt, 32'd1);
        drain();
        @(negedge clk);
        e_rn = 5'd5;
        #1;
        push("lu_rt_stall", SelStall, 32'd1);
        drain();
        e_rn = 5'd0;
        #1;
        push("lu_rn0_stall", SelStall, 32'd0);
        drain();
        e_wreg = 1'b0; e_m2reg = 1'b0;
        tick();
        push("jr_loaded", SelDinst, InstJr);
        push("lu_scnt_kept", SelStallCnt, 32'd1);
        drain();

        // jr: redirect to rs_data; branch hazard on $31 suppresses it.
        @(negedge clk);
        rs_data = 32'h40;
        pc4 = 32'hF0000010; inst = InstJ;
        #1;
        push("jr_pcsrc", SelPcsrc, 32'd2);
        push("jr_jpc", SelJpc, 32'h40);
        drain();
        e_wreg = 1'b1; e_rn = 5'd31;
        #1;
        push("jr_hz_stall", SelStall, 32'd1);
        push("jr_hz_pcsrc", SelPcsrc, 32'd0);
        drain();
        e_wreg = 1'b0; e_rn = 5'd0;
        tick();
        push("jr_flush", SelFlushCnt, 32'd2);
        push("jr_bubble", SelDvalid, 32'd0);
        drain();

        // j with upper PC bits.
        drive(32'hF0000010, InstJ);
        tick();
        #1;
        push("j_jpc", SelJpc, 32'hF0000400);
        push("j_pcsrc", SelPcsrc, 32'd2);
        drain();
        drive(32'h100, InstAdd);
        tick();
        push("j_flush", SelFlushCnt, 32'd3);
        drain();

        // Saturate stall_cnt with a long load-use stall.
        drive(32'h100, InstAdd);
        tick();
        @(negedge clk);
        e_wreg = 1'b1; e_m2reg = 1'b1; e_rn = 5'd5;
        repeat (65533) @(posedge clk);
        #1;
        push("sat_fffe", SelStallCnt, 32'hFFFE);
        drain();
        tick();
        push("sat_ffff", SelStallCnt, 32'hFFFF);
        drain();
        repeat (5) @(posedge clk);
        #1;
        push("sat_hold", SelStallCnt, 32'hFFFF);
        push("sat_fcnt", SelFlushCnt, 32'd3);
        push("sat_dinst", SelDinst, InstAdd);
        drain();

        // Asynchronous reset mid-stall, sampled before the next edge.
        @(negedge clk);
        #2;
        clrn = 1'b0;
        #1;
        push("arst_scnt", SelStallCnt, 32'd0);
        push("arst_fcnt", SelFlushCnt, 32'd0);
        push("arst_dvalid", SelDvalid, 32'd0);
        push("arst_stall", SelStall, 32'd0);
        push("arst_pcsrc", SelPcsrc, 32'd0);
        drain();
        #1;
        clrn = 1'b1;
        pc4 = 32'h200; inst = InstAddi;
        tick();
        push("post_rst_dinst", SelDinst, InstAddi);
        push("post_rst_scnt", SelStallCnt, 32'd0);
        drain();
        e_wreg = 1'b0; e_m2reg = 1'b0; e_rn = 5'd0;

        // Random beq/bne resolution against a reference target model.
        for (int k = 0; k < 6; k++) begin
            rp      = {$urandom(), 2'b00};
            imm     = 16'($urandom());
            use_bne = 1'($urandom_range(0, 1));
            ra      = 32'($urandom_range(0, 3));
            rb      = 32'($urandom_range(0, 3));
            ri      = {5'b00010, use_bne, 5'd1, 5'd2, imm};
            drive(rp, ri);
            tick();
            @(negedge clk);
            rs_data = ra; rt_data = rb;
            pc4 = 32'h0; inst = 32'h0;
            #1;
            taken = use_bne ? (ra != rb) : (ra == rb);
            push("rnd_bpc", SelBpc, bpc_model(rp, imm));
            push("rnd_pcsrc", SelPcsrc, {31'd0, taken});
            drain();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ifid_branch_unit.md
IFID_BRANCH_UNIT -- requirements
Module: ifid_branch_unit

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port clrn, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port pc4, input, 32, PC+4 of the instruction currently fetched.
REQ-004 SHALL have port inst, input, 32, instruction currently fetched.
REQ-005 SHALL have port rs_data, input, 32, register-file/forwarded value of d_rs.
REQ-006 SHALL have port rt_data, input, 32, register-file/forwarded value of d_rt.
REQ-007 SHALL have ports e_wreg, input, 1, and e_m2reg, input, 1: the EX-stage instruction writes a register, and that write comes from a load.
REQ-008 SHALL have port e_rn, input, 5, EX-stage destination register.
REQ-009 SHALL have port stall, output, 1, 1 = the fetch stage holds its PC this cycle.
REQ-010 SHALL have port pcsource, output, 2, next-PC select: 00 pc4, 01 bpc, 10 jpc, 11 never driven.
REQ-011 SHALL have ports bpc, output, 32, branch target, and jpc, output, 32, jump target.
REQ-012 SHALL have ports d_pc4, output, 32, and d_inst, output, 32: the IF/ID register contents.
REQ-013 SHALL have port d_valid, output, 1, d_inst is a real instruction and not a bubble.
REQ-014 SHALL have ports d_rs, output, 5, d_inst[25:21], and d_rt, output, 5, d_inst[20:16].
REQ-015 SHALL have ports stall_cnt, output, 16, and flush_cnt, output, 16: performance counters.

Function
REQ-016 SHALL decode d_inst as follows: beq = op 000100; bne = op 000101; j = op 000010; jal = op 000011; jr = op 000000 with funct 001000.
REQ-017 SHALL compute bpc = d_pc4 + (sign-extended d_inst[15:0] << 2), modulo 2^32, with wrap-around permitted.
REQ-018 SHALL drive jpc = {d_pc4[31:28], d_inst[25:0], 2'b00} for j/jal, rs_data for jr, and 0 otherwise.
REQ-019 SHALL assert load-use hazard when d_valid, e_wreg, e_m2reg, e_rn != 0, and e_rn equals d_rs or d_rt all hold.
REQ-020 SHALL assert branch hazard when d_valid, d_inst is beq/bne/jr, e_wreg, e_rn != 0, and e_rn matches a register that instruction reads (rs and rt for beq/bne, rs for jr).
REQ-021 SHALL make stall = load-use hazard OR branch hazard, computed combinationally in the same cycle.
REQ-022 SHALL, while stall = 1, force pcsource = 00, hold d_pc4/d_inst/d_valid, and suppress redirect.
REQ-023 SHALL, when stall = 0 and d_valid, set pcsource = 01 for beq with rs_data == rt_data or bne with rs_data != rt_data, 10 for j/jal/jr, and 00 otherwise.
REQ-024 SHALL have no delay slot: on an edge where pcsource != 00, load a bubble into IF/ID (d_inst = 0, d_valid = 0, d_pc4 = pc4).
REQ-025 SHALL otherwise, with stall = 0, load d_pc4 <= pc4, d_inst <= inst, d_valid <= 1 on each edge.
REQ-026 SHALL give one cycle of redirect latency: the target instruction reaches d_inst two edges after the branch enters ID.
REQ-027 SHALL increment stall_cnt on every edge with stall = 1, and flush_cnt on every edge with pcsource != 00; both saturate at 16'hFFFF.
REQ-028 SHALL never decode a bubble (d_valid = 0) as a branch, even when d_inst matches an opcode.

Reset
REQ-029 SHALL, while clrn = 0 and independent of clk, set d_pc4 = 0, d_inst = 0, d_valid = 0, stall_cnt = 0, and flush_cnt = 0.
REQ-030 SHALL therefore produce stall = 0 and pcsource = 00 during reset.
REQ-031 SHALL, when reset is asserted mid-stall or mid-redirect, discard the pending action and start the first edge after release with a plain fetch.

Verification
REQ-032 SHALL cover: after reset, inst = 0x20010005 at pc4 = 0x4, one edge -> d_inst = 0x20010005, d_valid = 1, pcsource = 00, stall = 0.
REQ-033 SHALL cover: d_inst = beq $1,$2,+3 (0x10220003), d_pc4 = 0x10, rs_data = rt_data = 7 -> pcsource = 01, bpc = 0x1C; next edge -> d_valid = 0, flush_cnt = 1.
REQ-034 SHALL cover: the same beq with rs_data = 7, rt_data = 8 -> pcsource = 00, no bubble, flush_cnt unchanged.
REQ-035 SHALL cover: d_inst = add using $3, e_m2reg = 1, e_wreg = 1, e_rn = 3 -> stall = 1, d_inst held, stall_cnt = 1; e_rn = 0 -> stall = 0.
REQ-036 SHALL cover: d_inst = jr $31, rs_data = 0x40, no hazard -> pcsource = 10, jpc = 0x40; j 0x100 with d_pc4 = 0xF0000010 -> jpc = 0xF0000400.
REQ-037 SHALL cover: stall_cnt preset to 0xFFFF via a long stall sequence, further stalls -> stays 0xFFFF; clrn pulsed low asynchronously -> all counters 0 before the next edge.
